// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch stage.
package fetch_pkg;

  typedef struct packed {
    logic [31:0] pc;
    logic        pred;
    logic        filled;
    logic [31:0] data;
  } fetch_entry_t;

  localparam logic [31:0] PC_STEP          = 32'd4;
  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

endpackage

// File: rtl/fetch_queue.sv
// Reservation FIFO: entries are allocated at request time and filled in order as
// responses return; the head is only presented once its data has arrived.
module fetch_queue
  import fetch_pkg::*;
#(
  parameter int unsigned DEPTH = 4,
  localparam int unsigned PtrW = $clog2(DEPTH),
  localparam int unsigned CntW = PtrW + 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            flush_i,
  input  logic            alloc_i,
  input  logic [31:0]     alloc_pc_i,
  input  logic            alloc_pred_i,
  input  logic            fill_i,
  input  logic [31:0]     fill_data_i,
  input  logic            pop_i,
  output logic            head_valid_o,
  output logic [31:0]     head_pc_o,
  output logic            head_pred_o,
  output logic [31:0]     head_data_o,
  output logic [CntW-1:0] count_o,
  output logic [CntW-1:0] unfilled_o
);

  fetch_entry_t entries_q [DEPTH];
  fetch_entry_t entries_d [DEPTH];
  logic [PtrW-1:0] alloc_ptr_q, alloc_ptr_d;
  logic [PtrW-1:0] fill_ptr_q, fill_ptr_d;
  logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0] count_q, count_d;
  logic [CntW-1:0] unfilled_q, unfilled_d;
  fetch_entry_t    head;

  always_comb begin
    entries_d   = entries_q;
    alloc_ptr_d = alloc_ptr_q;
    fill_ptr_d  = fill_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    count_d     = count_q;
    unfilled_d  = unfilled_q;
    if (flush_i) begin
      for (int unsigned i = 0; i < DEPTH; i++) entries_d[i].filled = 1'b0;
      alloc_ptr_d = '0;
      fill_ptr_d  = '0;
      rd_ptr_d    = '0;
      count_d     = '0;
      unfilled_d  = '0;
    end else begin
      // Alloc, fill and pop always target distinct entries, so their order is free.
      if (alloc_i) begin
        entries_d[alloc_ptr_q] = '{pc: alloc_pc_i, pred: alloc_pred_i, filled: 1'b0, data: '0};
        alloc_ptr_d = alloc_ptr_q + 1'b1;
      end
      if (fill_i) begin
        entries_d[fill_ptr_q].data   = fill_data_i;
        entries_d[fill_ptr_q].filled = 1'b1;
        fill_ptr_d = fill_ptr_q + 1'b1;
      end
      if (pop_i) rd_ptr_d = rd_ptr_q + 1'b1;
      count_d    = count_q + CntW'(alloc_i) - CntW'(pop_i);
      unfilled_d = unfilled_q + CntW'(alloc_i) - CntW'(fill_i);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      entries_q   <= '{default: '0};
      alloc_ptr_q <= '0;
      fill_ptr_q  <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      unfilled_q  <= '0;
    end else begin
      entries_q   <= entries_d;
      alloc_ptr_q <= alloc_ptr_d;
      fill_ptr_q  <= fill_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      unfilled_q  <= unfilled_d;
    end
  end

  assign head         = entries_q[rd_ptr_q];
  assign head_valid_o = (count_q != '0) && head.filled;
  assign head_pc_o    = head.pc;
  assign head_pred_o  = head.pred;
  assign head_data_o  = head.data;
  assign count_o      = count_q;
  assign unfilled_o   = unfilled_q;

endmodule

// File: rtl/instr_fetch_unit.sv
// Fetch stage: owns the fetch PC, issues in-order memory requests and drops stale
// responses after a redirect. Define FETCH_BP_EN to follow branch-predictor targets.
module instr_fetch_unit
  import fetch_pkg::*;
#(
  parameter int unsigned DEPTH    = 4,
  parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_req_addr,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  output logic [31:0] bp_pc,
  input  logic        bp_taken,
  input  logic [31:0] bp_target,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  input  logic        stall_d,
  output logic        valid_d,
  output logic [31:0] instr_d,
  output logic [31:0] pc_plus4_d,
  output logic        pred_taken_d
);

  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned CntW = PtrW + 1;
  localparam int unsigned SumW = CntW + 1;
  localparam logic [SumW-1:0] DepthLim = SumW'(DEPTH);

  logic [31:0]     fetch_pc_q, fetch_pc_d;
  logic [CntW-1:0] discard_q, discard_d;
  logic [CntW-1:0] count, unfilled;
  logic [31:0]     pc_next, head_pc, head_data;
  logic            pred_next, head_valid, head_pred;
  logic            accept, rsp_drop, fill, pop;

`ifdef FETCH_BP_EN
  assign pred_next = bp_taken;
  assign pc_next   = bp_taken ? bp_target : fetch_pc_q + PC_STEP;
`else
  logic unused_bp;
  assign unused_bp = ^{bp_taken, bp_target};
  assign pred_next = 1'b0;
  assign pc_next   = fetch_pc_q + PC_STEP;
`endif

  // Never let outstanding responses (stale + live) exceed the queue's tracking range.
  assign imem_req_valid = ~rst & ~redirect & ({1'b0, count} < DepthLim)
                        & (({1'b0, discard_q} + {1'b0, unfilled}) < DepthLim);
  assign imem_req_addr  = fetch_pc_q;
  assign bp_pc          = fetch_pc_q;

  assign accept   = imem_req_valid & imem_req_ready;
  assign rsp_drop = imem_rsp_valid & (discard_q != '0);
  assign fill     = imem_rsp_valid & ~rsp_drop & ~redirect;
  assign pop      = head_valid & ~stall_d & ~redirect;

  always_comb begin
    fetch_pc_d = fetch_pc_q;
    discard_d  = discard_q;
    if (redirect) begin
      fetch_pc_d = redirect_pc;
      discard_d  = discard_q + unfilled - CntW'(imem_rsp_valid);
    end else begin
      if (accept) fetch_pc_d = pc_next;
      if (rsp_drop) discard_d = discard_q - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_pc_q <= RESET_PC;
      discard_q  <= '0;
    end else begin
      fetch_pc_q <= fetch_pc_d;
      discard_q  <= discard_d;
    end
  end

  fetch_queue #(
    .DEPTH(DEPTH)
  ) u_queue (
    .clk          (clk),
    .rst          (rst),
    .flush_i      (redirect),
    .alloc_i      (accept),
    .alloc_pc_i   (fetch_pc_q),
    .alloc_pred_i (pred_next),
    .fill_i       (fill),
    .fill_data_i  (imem_rsp_data),
    .pop_i        (pop),
    .head_valid_o (head_valid),
    .head_pc_o    (head_pc),
    .head_pred_o  (head_pred),
    .head_data_o  (head_data),
    .count_o      (count),
    .unfilled_o   (unfilled)
  );

  assign valid_d      = head_valid;
  assign instr_d      = head_valid ? head_data : '0;
  assign pc_plus4_d   = head_valid ? head_pc + PC_STEP : '0;
  assign pred_taken_d = head_valid & head_pred;

endmodule
